tmr_obi_data_voter: RTL and testbench
=====================================

// Module: tmr_obi_data_voter
// PURPOSE
// - Sits between the three cve2 data ports of ext_cpu_system (core_data_req_o/core_data_resp_i) and the single OBI data master on the system bus.
// - Synchronises the three harts' data requests and majority-votes them into one bus transaction.
// - Broadcasts the single bus response back to the participating harts.
// - Flags per-hart disagreement and unrecoverable divergence (triple-modular-redundant lockstep).
// PARAMETERS
// - SKEW_MAX  default 8   max cycles between first and last hart request before voting with what is present
// - CNT_W     default 16  width of per-hart mismatch counters (used only with TMR_VOTER_CNT_EN)
// PORTS
// - clk_i           in   1              clock
// - rst_ni          in   1              asynchronous active-low reset
// - core_req_i      in   obi_req_t[3]   data requests from harts 0..2
// - core_resp_o     out  obi_resp_t[3]  gnt/rvalid/rdata to harts 0..2
// - bus_req_o       out  obi_req_t      voted request to system bus
// - bus_resp_i      in   obi_resp_t     system bus response
// - fault_o         out  3              1-cycle pulse per hart voted out or absent at issue
// - fatal_o         out  1              sticky: no majority, voter halted
// - mismatch_cnt_o  out  3*CNT_W        saturating per-hart fault counts (hart0 in LSBs)
// BEHAVIOUR
// - One clock (clk_i); asynchronous active-low reset rst_ni; all flops reset on rst_ni low.
// - Reset values: bus_req_o all '0; core_resp_o all '0; fault_o 0; fatal_o 0; counters 0; FSM=IDLE.
// - One outstanding transaction only; no pipelining.
// - FSM states:
//   - IDLE: all 3 req high -> latch requests, VOTE. Any req high -> WAIT_ALL, skew counter=1.
//   - WAIT_ALL: counter++ each cycle. All 3 high -> VOTE.
//     - counter==SKEW_MAX -> VOTE with the present harts; absent harts are marked faulty.
//   - VOTE (1 cycle): compare {addr,we,be,wdata} pairwise; wdata is ignored when we=0.
//     - Majority = any pair agreeing, checked A==B, then A==C, then B==C.
//     - Hart outside the majority, or absent -> fault_o[i] pulses this cycle.
//     - Fewer than 2 agreeing present harts -> fatal_o=1, HALT.
//     - Otherwise drive bus_req_o with the majority, req=1 -> ISSUE.
//   - ISSUE: hold bus_req_o stable until bus_resp_i.gnt.
//     - Same cycle as gnt: core_resp_o[i].gnt=1 for every hart with req high; bus_req_o.req drops next cycle -> WAIT_R.
//   - WAIT_R: on bus_resp_i.rvalid, core_resp_o[i].rvalid=1 for harts granted in ISSUE.
//     - rdata broadcast to all harts (combinational pass-through) -> IDLE.
//   - HALT: no gnt/rvalid issued; bus_req_o.req=0; exit only by reset.
// - Latency with no skew: all reqs at cycle 0 -> bus req at cycle 2; hart gnt same cycle as bus gnt.
// - A late hart arriving after VOTE is not granted for this transaction; it is handled as a new request from IDLE (software resync).
// - gnt and rvalid in the same bus cycle are illegal for the bus slave and need no handling.
// - Reset mid-transaction: bus_req_o.req drops asynchronously; no response is replayed.
// - Skew counter width = $clog2(SKEW_MAX+1); SKEW_MAX>=1.
// CONFIGURATION
// - TMR_VOTER_CNT_EN defined: each fault_o[i] pulse increments mismatch_cnt_o[i], saturating at 2^CNT_W-1.
//   - Counters cleared only by reset.
// - TMR_VOTER_CNT_EN undefined: mismatch_cnt_o tied to '0 and no counter flops are built.
// - All other behaviour is identical in both builds.
// TESTING
// - Lockstep read: 3 harts req addr=0x1000 we=0 at cycle 0; bus gnt cycle 2; rvalid rdata=0xCAFE cycle 4.
//   - Required: all 3 gnt at cycle 2, all 3 rvalid rdata=0xCAFE at cycle 4, fault_o=0.
// - Single-hart data upset: hart1 wdata=0xDEAD, harts 0/2 wdata=0xBEEF, addr 0x2000, we=1.
//   - Required: bus wdata=0xBEEF, fault_o=3'b010 for 1 cycle; counter1=1 with CNT_EN.
// - Skew: hart2 req 5 cycles after harts 0/1, SKEW_MAX=8.
//   - Required: single bus transaction issued 2 cycles after hart2 req, fault_o=0.
// - Absent hart: harts 0/1 req, hart2 silent, SKEW_MAX=8.
//   - Required: bus req issued after timeout, fault_o=3'b100, hart2 receives no gnt.
// - Divergence: 3 different addr 0x10/0x20/0x30.
//   - Required: fatal_o=1 stays high, bus_req_o.req never asserts until rst_ni low.
// - Reset in ISSUE with gnt withheld: assert rst_ni=0.
//   - Required: bus_req_o.req=0 immediately, FSM=IDLE, fatal_o=0, counters=0.

Source files
------------

// File: rtl/tmr_obi_data_voter.sv
// tmr_obi_data_voter
// Triple-modular-redundant lockstep voter for the three cve2 OBI data ports.
// It waits for all three harts, or at most SKEW_MAX cycles for late harts.
// It majority-votes {addr, we, be, wdata} and issues one transaction to the
// system bus. The single response is then broadcast back to the harts that
// took part in the vote.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   core_req_i[2:0]      per-hart request
//   core_addr_i          per-hart address (hart0 in LSBs, ADDR_W each)
//   core_we_i[2:0]       per-hart write enable
//   core_be_i            per-hart byte enables (DATA_W/8 each)
//   core_wdata_i         per-hart write data (DATA_W each)
//   core_gnt_o[2:0]      per-hart grant
//   core_rvalid_o[2:0]   per-hart read-valid
//   core_rdata_o         bus rdata broadcast to each hart slot
//   bus_req_o/addr/we/be/wdata   voted request to the system bus
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i   system bus response
//   fault_o[2:0]         1-cycle pulse per hart voted out or absent
//   fatal_o              sticky: no majority, voter halted until reset
//   mismatch_cnt_o       saturating per-hart fault counts (hart0 in LSBs)
//
// Build option: define TMR_VOTER_CNT_EN to build the per-hart mismatch
// counters. When it is undefined, mismatch_cnt_o is tied to zero.

module tmr_obi_data_voter #(
   parameter int SKEW_MAX = 8,
   parameter int CNT_W    = 16,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [2:0]                core_req_i,
   input  logic [3*ADDR_W-1:0]       core_addr_i,
   input  logic [2:0]                core_we_i,
   input  logic [3*(DATA_W/8)-1:0]   core_be_i,
   input  logic [3*DATA_W-1:0]       core_wdata_i,
   output logic [2:0]                core_gnt_o,
   output logic [2:0]                core_rvalid_o,
   output logic [3*DATA_W-1:0]       core_rdata_o,
   output logic                      bus_req_o,
   output logic [ADDR_W-1:0]         bus_addr_o,
   output logic                      bus_we_o,
   output logic [DATA_W/8-1:0]       bus_be_o,
   output logic [DATA_W-1:0]         bus_wdata_o,
   input  logic                      bus_gnt_i,
   input  logic                      bus_rvalid_i,
   input  logic [DATA_W-1:0]         bus_rdata_i,
   output logic [2:0]                fault_o,
   output logic                      fatal_o,
   output logic [3*CNT_W-1:0]        mismatch_cnt_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int SKW_W = $clog2(SKEW_MAX + 1);
   localparam int KEY_W = ADDR_W + 1 + BE_W + DATA_W;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_ALL = 3'd1;
   localparam logic [2:0] S_VOTE     = 3'd2;
   localparam logic [2:0] S_ISSUE    = 3'd3;
   localparam logic [2:0] S_WAIT_R   = 3'd4;
   localparam logic [2:0] S_HALT     = 3'd5;

   logic [2:0]              state_q;
   logic [SKW_W-1:0]        skew_q;
   logic [2:0]              present_q;
   logic [2:0]              gnt_mask_q;
   logic [3*ADDR_W-1:0]     addr_q;
   logic [2:0]              we_q;
   logic [3*BE_W-1:0]       be_q;
   logic [3*DATA_W-1:0]     wdata_q;

   // Write data only takes part in the comparison for writes.
   function automatic logic [KEY_W-1:0] make_key(input logic [ADDR_W-1:0] addr,
                                                 input logic              we,
                                                 input logic [BE_W-1:0]   be,
                                                 input logic [DATA_W-1:0] wdata);
      return {addr, we, be, (we ? wdata : {DATA_W{1'b0}})};
   endfunction

   logic [KEY_W-1:0]  key [3];
   logic [KEY_W-1:0]  maj_key;
   logic              eq_ab, eq_ac, eq_bc, have_maj, sel_a;
   logic [2:0]        in_maj;
   logic [ADDR_W-1:0] maj_addr;
   logic              maj_we;
   logic [BE_W-1:0]   maj_be;
   logic [DATA_W-1:0] maj_wdata;
   logic              latch_en;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         key[i] = make_key(addr_q[i*ADDR_W +: ADDR_W], we_q[i],
                           be_q[i*BE_W +: BE_W], wdata_q[i*DATA_W +: DATA_W]);
      end
      eq_ab    = present_q[0] & present_q[1] & (key[0] == key[1]);
      eq_ac    = present_q[0] & present_q[2] & (key[0] == key[2]);
      eq_bc    = present_q[1] & present_q[2] & (key[1] == key[2]);
      have_maj = eq_ab | eq_ac | eq_bc;
      // Hart A is the majority source whenever it takes part in a pair.
      sel_a    = eq_ab | eq_ac;
      maj_key  = sel_a ? key[0] : key[1];
      for (int i = 0; i < 3; i++) begin
         in_maj[i] = have_maj & present_q[i] & (key[i] == maj_key);
      end
      maj_addr  = sel_a ? addr_q[0 +: ADDR_W]  : addr_q[ADDR_W +: ADDR_W];
      maj_we    = sel_a ? we_q[0]              : we_q[1];
      maj_be    = sel_a ? be_q[0 +: BE_W]      : be_q[BE_W +: BE_W];
      maj_wdata = sel_a ? wdata_q[0 +: DATA_W] : wdata_q[DATA_W +: DATA_W];

      latch_en = ((state_q == S_IDLE) && (&core_req_i)) ||
                 ((state_q == S_WAIT_ALL) &&
                  ((&core_req_i) || (skew_q == SKW_W'(SKEW_MAX))));
   end

   assign fault_o       = (state_q == S_VOTE) ? ~in_maj : 3'b000;
   assign fatal_o       = (state_q == S_HALT) || ((state_q == S_VOTE) && !have_maj);
   // Late harts that were not present at the vote get no grant.
   assign core_gnt_o    = ((state_q == S_ISSUE) && bus_gnt_i) ? (present_q & core_req_i) : 3'b000;
   assign core_rvalid_o = ((state_q == S_WAIT_R) && bus_rvalid_i) ? gnt_mask_q : 3'b000;
   assign core_rdata_o  = (state_q == S_WAIT_R) ? {3{bus_rdata_i}} : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         skew_q      <= '0;
         present_q   <= '0;
         gnt_mask_q  <= '0;
         addr_q      <= '0;
         we_q        <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         bus_req_o   <= 1'b0;
         bus_addr_o  <= '0;
         bus_we_o    <= 1'b0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
      end else begin
         if (latch_en) begin
            present_q <= core_req_i;
            addr_q    <= core_addr_i;
            we_q      <= core_we_i;
            be_q      <= core_be_i;
            wdata_q   <= core_wdata_i;
         end
         case (state_q)
            S_IDLE: begin
               if (&core_req_i) begin
                  state_q <= S_VOTE;
               end else if (|core_req_i) begin
                  state_q <= S_WAIT_ALL;
                  skew_q  <= SKW_W'(1);
               end
            end
            S_WAIT_ALL: begin
               if (latch_en) state_q <= S_VOTE;
               else          skew_q  <= skew_q + SKW_W'(1);
            end
            S_VOTE: begin
               if (have_maj) begin
                  bus_req_o   <= 1'b1;
                  bus_addr_o  <= maj_addr;
                  bus_we_o    <= maj_we;
                  bus_be_o    <= maj_be;
                  bus_wdata_o <= maj_wdata;
                  state_q     <= S_ISSUE;
               end else begin
                  state_q <= S_HALT;
               end
            end
            S_ISSUE: begin
               if (bus_gnt_i) begin
                  bus_req_o  <= 1'b0;
                  gnt_mask_q <= present_q & core_req_i;
                  state_q    <= S_WAIT_R;
               end
            end
            S_WAIT_R: begin
               if (bus_rvalid_i) state_q <= S_IDLE;
            end
            S_HALT:  state_q <= S_HALT;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef TMR_VOTER_CNT_EN
   logic [CNT_W-1:0] cnt_q [3];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (fault_o[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign mismatch_cnt_o = {cnt_q[2], cnt_q[1], cnt_q[0]};
`else
   assign mismatch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tmr_obi_data_voter.sv
module tb_tmr_obi_data_voter;

   localparam int SKEW_MAX = 8;
   localparam int CNT_W    = 2;
   localparam int AW       = 32;
   localparam int DW       = 32;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic [2:0]        core_req_i;
   logic [3*AW-1:0]   core_addr_i;
   logic [2:0]        core_we_i;
   logic [3*(DW/8)-1:0] core_be_i;
   logic [3*DW-1:0]   core_wdata_i;
   logic [2:0]        core_gnt_o;
   logic [2:0]        core_rvalid_o;
   logic [3*DW-1:0]   core_rdata_o;
   logic              bus_req_o;
   logic [AW-1:0]     bus_addr_o;
   logic              bus_we_o;
   logic [DW/8-1:0]   bus_be_o;
   logic [DW-1:0]     bus_wdata_o;
   logic              bus_gnt_i;
   logic              bus_rvalid_i;
   logic [DW-1:0]     bus_rdata_i;
   logic [2:0]        fault_o;
   logic              fatal_o;
   logic [3*CNT_W-1:0] mismatch_cnt_o;

   tmr_obi_data_voter #(.SKEW_MAX(SKEW_MAX), .CNT_W(CNT_W), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
      .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
      .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
      .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
      .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
      .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
      .fault_o(fault_o), .fatal_o(fatal_o), .mismatch_cnt_o(mismatch_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0]      mask;
      logic [3*AW-1:0] addr;
      logic [2:0]      we;
      logic [11:0]     be;
      logic [3*DW-1:0] wdata;
      logic [DW-1:0]   rdata;
      logic            efatal;
      logic [2:0]      efault;
      logic [AW-1:0]   eaddr;
      logic            ewe;
      logic [3:0]      ebe;
      logic [DW-1:0]   ewdata;
      int              eissue;
   } vec_t;

   vec_t vecs[$];
   int n_cmp = 0;
   int n_bad = 0;
   logic [CNT_W-1:0] exp_cnt [3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3*CNT_W-1:0] exp_cnt_vec();
`ifdef TMR_VOTER_CNT_EN
      return {exp_cnt[2], exp_cnt[1], exp_cnt[0]};
`else
      return '0;
`endif
   endfunction

   task automatic add_vec(input logic [2:0] mask, input logic [31:0] a0, a1, a2,
                          input logic [2:0] we, input logic [3:0] b0, b1, b2,
                          input logic [31:0] d0, d1, d2, input logic [31:0] rdata,
                          input logic efatal, input logic [2:0] efault,
                          input logic [31:0] eaddr, input logic ewe, input logic [3:0] ebe,
                          input logic [31:0] ewdata, input int eissue);
      vec_t v;
      v.mask = mask; v.addr = {a2, a1, a0}; v.we = we; v.be = {b2, b1, b0};
      v.wdata = {d2, d1, d0}; v.rdata = rdata; v.efatal = efatal; v.efault = efault;
      v.eaddr = eaddr; v.ewe = ewe; v.ebe = ebe; v.ewdata = ewdata; v.eissue = eissue;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      core_req_i = '0; core_addr_i = '0; core_we_i = '0; core_be_i = '0; core_wdata_i = '0;
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      for (int i = 0; i < 3; i++) exp_cnt[i] = '0;
   endtask

   // Drives one request set at cycle 0, answers the bus (gnt as soon as
   // bus_req is seen, rvalid two cycles later) and checks the outcome.
   task automatic run_vec(input vec_t v, input string nm);
      int issue_cyc = -1;
      int gnt_cyc = -1;
      int fault_cycles = 0;
      logic [2:0] fault_acc = 3'b000;
      logic fatal_seen = 1'b0;
      logic gnt_done = 1'b0;
      logic done = 1'b0;
      logic [2:0] gnt_seen = 3'b000;
      logic [2:0] rv_seen = 3'b000;
      logic [3*DW-1:0] rd_seen = '0;
      logic [AW-1:0] baddr = '0;
      logic bwe = 1'b0;
      logic [3:0] bbe = '0;
      logic [DW-1:0] bwd = '0;
      core_req_i = v.mask; core_addr_i = v.addr; core_we_i = v.we;
      core_be_i = v.be; core_wdata_i = v.wdata; bus_rdata_i = v.rdata;
      for (int c = 0; c < 40 && !done; c++) begin
         bus_gnt_i    = bus_req_o && !gnt_done;
         bus_rvalid_i = gnt_done && (c == gnt_cyc + 2);
         if (bus_req_o && issue_cyc < 0) issue_cyc = c;
         @(negedge clk_i);
         fault_acc |= fault_o;
         if (fault_o != 3'b000) fault_cycles++;
         if (fatal_o) fatal_seen = 1'b1;
         if (bus_gnt_i) begin
            gnt_done = 1'b1; gnt_cyc = c; gnt_seen = core_gnt_o;
            baddr = bus_addr_o; bwe = bus_we_o; bbe = bus_be_o; bwd = bus_wdata_o;
         end
         if (bus_rvalid_i) begin
            rv_seen = core_rvalid_o; rd_seen = core_rdata_o; done = 1'b1;
         end
         if (fatal_seen && c >= 12) done = 1'b1;
         @(posedge clk_i); #1;
         if (gnt_done) core_req_i = 3'b000;
      end
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; core_req_i = 3'b000;
      chk({nm, ".fatal"}, fatal_seen, v.efatal);
      if (!v.efatal) begin
         chk({nm, ".fault"}, fault_acc, v.efault);
         chk({nm, ".fault_len"}, fault_cycles, (v.efault != 3'b000) ? 1 : 0);
         chk({nm, ".issue_cyc"}, issue_cyc, v.eissue);
         chk({nm, ".bus_addr"}, baddr, v.eaddr);
         chk({nm, ".bus_we"}, bwe, v.ewe);
         chk({nm, ".bus_be"}, bbe, v.ebe);
         if (v.ewe) chk({nm, ".bus_wdata"}, bwd, v.ewdata);
         chk({nm, ".hart_gnt"}, gnt_seen, v.mask);
         chk({nm, ".hart_rvalid"}, rv_seen, v.mask);
         chk({nm, ".rdata"}, rd_seen, {3{v.rdata}});
         for (int i = 0; i < 3; i++)
            if (v.efault[i]) exp_cnt[i] = (exp_cnt[i] == {CNT_W{1'b1}}) ? exp_cnt[i] : exp_cnt[i] + 1'b1;
         chk({nm, ".cnt"}, mismatch_cnt_o, exp_cnt_vec());
      end else begin
         chk({nm, ".no_issue"}, issue_cyc, -1);
         chk({nm, ".no_gnt"}, gnt_seen, 3'b000);
         do_reset();
         chk({nm, ".fatal_cleared"}, fatal_o, 1'b0);
      end
   endtask

   initial begin
      int first, rises, bad_cycles, gnt_bad;
      logic prev_req;
      logic [2:0] fault_acc, gnt_seen, rv_seen;
      logic [3*DW-1:0] rd_seen;

      for (int i = 0; i < 3; i++) exp_cnt[i] = '0;
      // Vector table: mask, addr0..2, we, be0..2, wdata0..2, rdata, fatal, fault, exp addr/we/be/wdata, issue cycle
      add_vec(3'b111, 32'h1000, 32'h1000, 32'h1000, 3'b000, 4'hF, 4'hF, 4'hF, 0, 0, 0, 32'hCAFE, 0, 3'b000, 32'h1000, 0, 4'hF, 0, 2);
      add_vec(3'b111, 32'h2000, 32'h2000, 32'h2000, 3'b111, 4'hF, 4'hF, 4'hF, 32'hBEEF, 32'hDEAD, 32'hBEEF, 32'h1, 0, 3'b010, 32'h2000, 1, 4'hF, 32'hBEEF, 2);
      add_vec(3'b011, 32'h3000, 32'h3000, 32'h0, 3'b000, 4'hF, 4'hF, 4'h0, 0, 0, 0, 32'h1234, 0, 3'b100, 32'h3000, 0, 4'hF, 0, 10);
      add_vec(3'b111, 32'h44, 32'h40, 32'h40, 3'b000, 4'h3, 4'h3, 4'h3, 0, 0, 0, 32'h55, 0, 3'b001, 32'h40, 0, 4'h3, 0, 2);
      add_vec(3'b111, 32'h50, 32'h50, 32'h50, 3'b000, 4'hF, 4'hF, 4'hF, 1, 2, 3, 32'h66, 0, 3'b000, 32'h50, 0, 4'hF, 0, 2);
      add_vec(3'b111, 32'h60, 32'h60, 32'h60, 3'b011, 4'hF, 4'hF, 4'hF, 7, 7, 7, 32'h77, 0, 3'b100, 32'h60, 1, 4'hF, 7, 2);
      add_vec(3'b111, 32'h70, 32'h70, 32'h70, 3'b111, 4'hF, 4'h3, 4'hF, 9, 9, 9, 32'h88, 0, 3'b010, 32'h70, 1, 4'hF, 9, 2);
      add_vec(3'b111, 32'h80, 32'h80, 32'h80, 3'b111, 4'h1, 4'h1, 4'h1, 32'h1234, 32'h9999, 32'h1234, 32'h99, 0, 3'b010, 32'h80, 1, 4'h1, 32'h1234, 2);
      add_vec(3'b111, 32'h90, 32'h90, 32'h90, 3'b111, 4'h1, 4'h1, 4'h1, 32'h5, 32'h6, 32'h5, 32'hAA, 0, 3'b010, 32'h90, 1, 4'h1, 32'h5, 2);
      add_vec(3'b110, 32'h0, 32'hA0, 32'hA0, 3'b110, 4'h0, 4'hC, 4'hC, 0, 32'h42, 32'h42, 32'hBB, 0, 3'b001, 32'hA0, 1, 4'hC, 32'h42, 10);
      add_vec(3'b010, 32'h0, 32'hB0, 32'h0, 3'b000, 4'h0, 4'hF, 4'h0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0);
      add_vec(3'b111, 32'h10, 32'h20, 32'h30, 3'b000, 4'hF, 4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0);
      add_vec(3'b110, 32'h0, 32'hC0, 32'hC4, 3'b000, 4'h0, 4'hF, 4'hF, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0);

      // Reset state, with response inputs active to show the outputs stay gated.
      rst_ni = 1'b0;
      idle_inputs();
      core_req_i = 3'b111; bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst.bus_req", bus_req_o, 1'b0);
      chk("rst.bus_addr", bus_addr_o, '0);
      chk("rst.gnt", core_gnt_o, 3'b000);
      chk("rst.rvalid", core_rvalid_o, 3'b000);
      chk("rst.rdata", core_rdata_o, '0);
      chk("rst.fault", fault_o, 3'b000);
      chk("rst.fatal", fatal_o, 1'b0);
      chk("rst.cnt", mismatch_cnt_o, '0);
      idle_inputs();
      @(posedge clk_i); #1 rst_ni = 1'b1;

      // Lockstep read, cycle by cycle.
      core_req_i = 3'b111; core_addr_i = {3{32'h1000}}; core_be_i = {3{4'hF}};
      fault_acc = 3'b000;
      @(negedge clk_i); fault_acc |= fault_o;
      @(posedge clk_i); #1;
      @(negedge clk_i); fault_acc |= fault_o;
      chk("ls.c1_no_req", bus_req_o, 1'b0);
      @(posedge clk_i); #1;
      bus_gnt_i = 1'b1;
      @(negedge clk_i); fault_acc |= fault_o;
      chk("ls.c2_bus_req", bus_req_o, 1'b1);
      chk("ls.c2_gnt", core_gnt_o, 3'b111);
      @(posedge clk_i); #1;
      bus_gnt_i = 1'b0; core_req_i = 3'b000;
      @(negedge clk_i);
      chk("ls.c3_req_dropped", bus_req_o, 1'b0);
      @(posedge clk_i); #1;
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFE;
      @(negedge clk_i);
      chk("ls.c4_rvalid", core_rvalid_o, 3'b111);
      chk("ls.c4_rdata", core_rdata_o, {3{32'hCAFE}});
      chk("ls.fault", fault_acc, 3'b000);
      @(posedge clk_i); #1;
      idle_inputs();

      // Skew: hart2 joins 5 cycles after harts 0/1.
      first = -1; rises = 0; prev_req = 1'b0; fault_acc = 3'b000;
      gnt_seen = '0; rv_seen = '0; rd_seen = '0;
      core_req_i = 3'b011; core_addr_i = {3{32'h500}}; core_be_i = {3{4'hF}};
      bus_rdata_i = 32'h600D;
      for (int c = 0; c < 30; c++) begin
         if (c == 5) core_req_i[2] = 1'b1;
         bus_gnt_i = bus_req_o && (first < 0 || c == first);
         if (bus_req_o && first < 0) begin first = c; bus_gnt_i = 1'b1; end
         bus_rvalid_i = (first >= 0) && (c == first + 2);
         @(negedge clk_i);
         fault_acc |= fault_o;
         if (bus_req_o && !prev_req) rises++;
         prev_req = bus_req_o;
         if (bus_gnt_i) gnt_seen = core_gnt_o;
         if (bus_rvalid_i) begin rv_seen = core_rvalid_o; rd_seen = core_rdata_o; end
         @(posedge clk_i); #1;
         if (first >= 0) core_req_i = 3'b000;
      end
      idle_inputs();
      chk("skew.issue_cyc", first, 7);
      chk("skew.one_txn", rises, 1);
      chk("skew.fault", fault_acc, 3'b000);
      chk("skew.gnt", gnt_seen, 3'b111);
      chk("skew.rvalid", rv_seen, 3'b111);
      chk("skew.rdata", rd_seen, {3{32'h600D}});

      // Table-driven vectors.
      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Divergence: fatal must hold and the bus must stay quiet.
      bad_cycles = 0; rises = 0; gnt_bad = 0;
      core_req_i = 3'b111; core_addr_i = {32'h30, 32'h20, 32'h10}; core_be_i = {3{4'hF}};
      bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk_i);
         if (c >= 1 && !fatal_o) bad_cycles++;
         if (bus_req_o) rises++;
         if (core_gnt_o != 3'b000 || core_rvalid_o != 3'b000) gnt_bad++;
         @(posedge clk_i); #1;
      end
      chk("div.fatal_held", bad_cycles, 0);
      chk("div.no_bus_req", rises, 0);
      chk("div.no_resp", gnt_bad, 0);
      do_reset();
      chk("div.fatal_after_rst", fatal_o, 1'b0);

      // Reset while in ISSUE with gnt withheld.
      run_vec(vecs[1], "pre_rst");
      core_req_i = 3'b111; core_addr_i = {3{32'h700}}; core_be_i = {3{4'hF}};
      first = -1;
      for (int c = 0; c < 6; c++) begin
         if (bus_req_o && first < 0) first = c;
         @(posedge clk_i); #1;
      end
      chk("rstiss.issued", first, 2);
      #2 rst_ni = 1'b0;
      #1;
      chk("rstiss.bus_req_async", bus_req_o, 1'b0);
      chk("rstiss.fatal", fatal_o, 1'b0);
      chk("rstiss.cnt", mismatch_cnt_o, '0);
      do_reset();
      run_vec(vecs[0], "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule
